uart_recv: RTL and testbench
============================

Name: uart_recv

Overview:
- UART receiver for the 9600-baud serial link, 8N1 framing.
- Companion to the project's UART transmitter; sits on the USB-UART RX pin.
- Synchronises the asynchronous line and samples each bit at its centre.
- Delivers each received byte with a one-cycle valid pulse; flags framing errors.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- BAUD_DIV, CLK_FREQ/BAUD (10416), clocks per bit. Derived localparam; do not override.
- HALF_DIV, BAUD_DIV/2 (5208), clocks from start-edge detect to start-bit centre. Derived localparam.
- PARITY_ODD, 0, used only with UART_RX_PARITY_EN. 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock, 100 MHz. Single clock domain.
- rst  input  1  reset; synchronous, active-high.
- din  input  1  serial RX line; asynchronous; idles high.
- data  output  8  last correctly received byte, LSB first on the line; held until the next good frame.
- valid  output  1  one-cycle pulse: data was updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch. Constant 0 without UART_RX_PARITY_EN.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: data=0, valid=0, frame_err=0, parity_err=0, busy=0. Synchroniser flops=1, state=IDLE, counters=0, armed=0.
- Reset applied mid-frame aborts the frame: no pulse, no data update. Reception resumes only after the line is seen high (armed rule).
- Synchroniser: din passes through 2 flops to give din_s. All decisions use din_s only; detection latency is 2 cycles.
- Baud counter: 14-bit, cleared on every state entry. An event ("tick") fires when the count reaches the current target minus 1.
- armed flag: set whenever din_s==1 in IDLE; cleared on leaving IDLE. Prevents a held-low line (break, or after a framing error) from retriggering.
- IDLE: if armed && din_s==0, go to START.
- START: target HALF_DIV. On tick:
  - din_s==0: go to DATA, bit_idx=0.
  - din_s==1: treat as a glitch; return to IDLE. No pulse.
- DATA: target BAUD_DIV. On each tick, shift din_s into shift_reg MSB; after 8 samples the first bit sits in bit 0 (LSB first). bit_idx counts 0..7 (3 bits, no wrap beyond 7). After the tick at bit_idx==7, go to STOP (or PARITY when enabled).
- STOP: target BAUD_DIV. On tick:
  - din_s==1: data<=shift_reg, valid=1 for the next cycle.
  - din_s==0: frame_err=1 for one cycle; data unchanged.
  - Either way, go to IDLE.
- Output latency: valid rises 1 cycle after the stop-bit centre sample, i.e. ~9.5 bit times + 3 cycles after the falling edge on din.
- The receiver is ready for the next start bit from the cycle it enters IDLE, half a bit before the stop bit ends, so back-to-back frames need no idle gap.
- valid, frame_err and parity_err are mutually exclusive in any cycle. Each is never high for 2 consecutive cycles.
- No backpressure: a consumer that misses a valid pulse loses the byte. data still holds the value until overwritten.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1/8O1. State PARITY (target BAUD_DIV) is inserted between DATA and STOP.
  - The parity bit is sampled and compared with ^shift_reg ^ PARITY_ODD.
  - At STOP with stop bit high: if the parity bit matched, assert valid and update data. If it mismatched, assert parity_err instead, with no data update.
  - A low stop bit always gives frame_err only, never parity_err.
- Undefined: no PARITY state; parity_err tied 0; 8N1 framing as above.

Test Plan:
- 8N1 frame 0x55, bit period 10416 clk -> exactly one valid pulse, data=0x55, frame_err never high, busy low afterwards.
- Two back-to-back frames 0xA5 then 0x3C, no idle gap -> two valid pulses ~104160 clk apart; data=0xA5 then 0x3C.
- din low for 200 clk, then high -> returns to IDLE after HALF_DIV; no valid, no frame_err; data unchanged.
- Frame 0xF0 with stop bit low, line then held low for 3 bit times -> one frame_err pulse, no valid, data holds previous value. No new frame until din goes high and a fresh start bit arrives.
- rst pulsed during bit 4 of frame 0x81 -> outputs reset to 0 and no pulse. A following clean frame 0x81 gives valid with data=0x81.
- With UART_RX_PARITY_EN, PARITY_ODD=0: frame 0x07 with parity bit 1 -> valid, data=0x07. Same frame with parity bit 0 -> one parity_err pulse, no valid.

Source files
------------

// File: rtl/uart_recv.sv
// 8N1 UART receiver: two-flop line synchroniser, centre-sampled bits, one-cycle result pulses.
// Define UART_RX_PARITY_EN for 8E1/8O1 framing with a parity check before the stop bit.
module uart_recv #(
    parameter int   CLK_FREQ   = 100000000,
    parameter int   BAUD       = 9600,
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam logic [13:0] FULL_LAST = 14'(BAUD_DIV - 1);
    localparam logic [13:0] HALF_LAST = 14'(HALF_DIV - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY     = 3'd4;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic        din_m;
    logic        din_s;
    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [13:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        armed;
    logic        tick;
    logic        par_ok;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_ok = (par_bit == (^shift_reg ^ PARITY_ODD));
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        tick     = (cnt == ((state == START) ? HALF_LAST : FULL_LAST));
        state_nx = state;
        unique case (state)
            IDLE:    if (armed && !din_s) state_nx = START;
            START:   if (tick) state_nx = din_s ? IDLE : DATA;
            DATA:    if (tick && bit_idx == 3'd7) state_nx = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            PARITY:  if (tick) state_nx = STOP;
`endif
            STOP:    if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_m      <= 1'b1;
            din_s      <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            armed      <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            din_m     <= din;
            din_s     <= din_m;
            state     <= state_nx;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (state == IDLE || state_nx != state || tick) cnt <= '0;
            else cnt <= cnt + 14'd1;
            // a line held low after a break or bad stop must go high before it can start a frame
            armed <= (state == IDLE) && (state_nx == IDLE) && (armed || din_s);
            if (state == START && tick) bit_idx <= '0;
            if (state == DATA && tick) begin
                shift_reg <= {din_s, shift_reg[7:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (state == PARITY && tick) par_bit <= din_s;
`endif
            if (state == STOP && tick) begin
                if (!din_s) begin
                    frame_err <= 1'b1;
                end else if (par_ok) begin
                    data  <= shift_reg;
                    valid <= 1'b1;
                end else begin
`ifdef UART_RX_PARITY_EN
                    parity_err <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// Randomised frame bench for uart_recv; expected pulses come from a frame-level model.
// Runs with a shortened bit period (16 clocks) so whole frames fit in a small cycle budget.
module tb_uart_recv;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int BIT      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_recv #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .PARITY_ODD(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .data(data),
        .valid(valid),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .busy(busy)
    );

    typedef struct {
        int         kind;
        logic [7:0] d;
        longint     cyc;
    } ev_t;

    ev_t        evq[$];
    longint     cyc = 0;
    int         excl_bad = 0;
    logic       pv = 1'b0;
    logic       pf = 1'b0;
    logic       pp = 1'b0;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] model_data = 8'h00;

    // records every result pulse and flags overlapping or stretched pulses
    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) excl_bad++;
        if ((valid && pv) || (frame_err && pf) || (parity_err && pp)) excl_bad++;
        pv = valid;
        pf = frame_err;
        pp = parity_err;
        e.d   = data;
        e.cyc = cyc;
        if (valid)      begin e.kind = 1; evq.push_back(e); end
        if (frame_err)  begin e.kind = 2; evq.push_back(e); end
        if (parity_err) begin e.kind = 3; evq.push_back(e); end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        drive(^b ^ par_flip, BIT);
`endif
        drive(stop, BIT);
    endtask

    // frame-level expectation: bad stop wins, then parity, otherwise a good byte
    task automatic expect_frame(input string tag, input logic [7:0] b, input logic stop,
                                input logic par_flip, output longint at);
        int kind;
        if (!stop) kind = 2;
`ifdef UART_RX_PARITY_EN
        else if (par_flip) kind = 3;
`endif
        else begin
            kind = 1;
            model_data = b;
        end
        at = 0;
        check({tag, "_npulse"}, evq.size(), 1);
        if (evq.size() > 0) begin
            check({tag, "_kind"}, evq[0].kind, kind);
            at = evq[0].cyc;
        end
        check({tag, "_data"}, {24'h0, data}, {24'h0, model_data});
        evq.delete();
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input logic stop,
                         input logic par_flip, output longint at);
        send_frame(b, stop, par_flip);
        expect_frame(tag, b, stop, par_flip, at);
    endtask

    initial begin
        longint t0;
        longint t1;
        logic   prev_stop;
        din = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'h0, data}, 0);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_perr", parity_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        drive(1'b1, 6);
        evq.delete();

        frame("f55", 8'h55, 1'b1, 1'b0, t0);
        drive(1'b1, BIT);
        check("f55_busy", busy, 0);

        frame("fA5", 8'hA5, 1'b1, 1'b0, t0);
        frame("f3C", 8'h3C, 1'b1, 1'b0, t1);
        check("b2b_gap", 32'(t1 - t0), 32'(FRAME_BITS * BIT));

        drive(1'b0, 3);
        drive(1'b1, 2 * BIT);
        check("glitch_npulse", evq.size(), 0);
        check("glitch_busy", busy, 0);
        check("glitch_data", {24'h0, data}, {24'h0, model_data});

        frame("fF0", 8'hF0, 1'b0, 1'b0, t0);
        drive(1'b0, 3 * BIT);
        check("brk_busy", busy, 0);
        check("brk_npulse", evq.size(), 0);
        drive(1'b1, 6);
        frame("after_brk", 8'h96, 1'b1, 1'b0, t0);

        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(1'(8'h81 >> i), BIT);
        drive(1'b0, BIT / 2);
        rst = 1'b1;
        drive(1'b0, 2);
        check("mid_rst_data", {24'h0, data}, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_npulse", evq.size(), 0);
        rst = 1'b0;
        drive(1'b0, BIT);
        drive(1'b1, 3 * FRAME_BITS * BIT);
        evq.delete();
        frame("f81", 8'h81, 1'b1, 1'b0, t0);

`ifdef UART_RX_PARITY_EN
        drive(1'b1, 4);
        frame("par_ok", 8'h07, 1'b1, 1'b0, t0);
        frame("par_bad", 8'h07, 1'b1, 1'b1, t0);
`endif

        prev_stop = 1'b1;
        for (int n = 0; n < 14; n++) begin
            logic [7:0] b;
            logic       stop;
            logic       flip;
            int         gap;
            b    = 8'($urandom);
            stop = ($urandom_range(4) != 0);
            flip = 1'b0;
`ifdef UART_RX_PARITY_EN
            flip = ($urandom_range(3) == 0);
`endif
            gap = prev_stop ? $urandom_range(6) : 4 + $urandom_range(10);
            if (gap > 0) drive(1'b1, gap);
            frame($sformatf("rnd%0d", n), b, stop, flip, t0);
            prev_stop = stop;
        end
        drive(1'b1, 2 * BIT);
        check("end_busy", busy, 0);
        check("pulse_excl", excl_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
